// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Multiplies use a shift-add loop over a 2*XLEN accumulator and divides use a
// restoring loop, one bit per cycle. Signed operands are reduced to
// magnitudes on accept and the sign is restored on the final iteration.
// Divide-by-zero, signed overflow and illegal encodings skip the loop.
module rv32m_muldiv_unit #(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic [XLEN-1:0]      rs1_val,
  input  logic [XLEN-1:0]      rs2_val,
  input  logic [TAG_WIDTH-1:0] tag_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      result,
  output logic [TAG_WIDTH-1:0] tag_out,
  output logic                 illegal
);

  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] F7_MULD = 7'b0000001;
  localparam int         CW      = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_INIT = CW'(XLEN - 1);
  localparam logic signed [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Two's-complement negation of a single-width value.
  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    return ~v + 1'b1;
  endfunction

  // Two's-complement negation of a double-width product.
  function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
    return ~v + 1'b1;
  endfunction

  // Magnitude of an operand that is signed only when sgn is set.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? neg_x(v) : v;
  endfunction

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [2:0]        f3;
  logic              sign_a, sign_b;
  logic [XLEN-1:0]   opa;      // multiplicand, or dividend shifting into quotient
  logic [XLEN-1:0]   opb;      // divisor magnitude
  logic [2*XLEN-1:0] acc;      // product accumulator, multiplier in low half
  logic [XLEN-1:0]   rem;      // partial remainder

  logic              accept, is_m, a_signed, b_signed, div_zero, div_ovf, fast;
  logic [XLEN-1:0]   fast_res;

  logic [XLEN:0]     mul_add;
  logic [2*XLEN-1:0] acc_nxt;
  logic [XLEN:0]     trial;
  logic              borrow;
  logic [XLEN-1:0]   rem_nxt, opa_nxt;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rmd, calc_res;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready;

  // Request decode: encoding check, operand signedness and fast-path results.
  always_comb begin
    is_m     = (opcode == OPC_OP) && (funct7 == F7_MULD);
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    div_zero = funct3[2] && (rs2_val == '0);
    div_ovf  = funct3[2] && !funct3[0] &&
               ($signed(rs1_val) == SMIN) && (rs2_val == '1);
    fast     = !is_m || div_zero || div_ovf;
    fast_res = '0;
    if (is_m && div_zero)
      fast_res = funct3[1] ? rs1_val : '1;
    else if (is_m && div_ovf)
      fast_res = funct3[1] ? '0 : rs1_val;
  end

  // One iteration step plus sign-fixed result selection for the last step.
  always_comb begin
    mul_add = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opa} : '0);
    acc_nxt = {mul_add, acc[XLEN-1:1]};
    trial   = {rem, opa[XLEN-1]} - {1'b0, opb};
    borrow  = trial[XLEN];
    rem_nxt = borrow ? {rem[XLEN-2:0], opa[XLEN-1]} : trial[XLEN-1:0];
    opa_nxt = {opa[XLEN-2:0], ~borrow};
    prod    = (sign_a ^ sign_b) ? neg_2x(acc_nxt) : acc_nxt;
    quo     = (sign_a ^ sign_b) ? neg_x(opa_nxt) : opa_nxt;
    rmd     = sign_a ? neg_x(rem_nxt) : rem_nxt;
    case (f3)
      3'b000:  calc_res = prod[XLEN-1:0];
      3'b001,
      3'b010,
      3'b011:  calc_res = prod[2*XLEN-1:XLEN];
      3'b100,
      3'b101:  calc_res = quo;
      default: calc_res = rmd;
    endcase
  end

  // Control FSM: IDLE accepts, CALC iterates, DONE holds the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          state <= fast ? S_DONE : S_CALC;
          cnt   <= CNT_INIT;
        end
        S_CALC: begin
          if (cnt == '0) state <= S_DONE;
          else           cnt   <= cnt - CW'(1);
        end
        S_DONE: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath: latch magnitudes on accept, iterate in CALC, register result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3      <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      opa     <= '0;
      opb     <= '0;
      acc     <= '0;
      rem     <= '0;
      result  <= '0;
      tag_out <= '0;
      illegal <= 1'b0;
    end else if (accept) begin
      f3      <= funct3;
      sign_a  <= a_signed && rs1_val[XLEN-1];
      sign_b  <= b_signed && rs2_val[XLEN-1];
      opa     <= mag(rs1_val, a_signed);
      opb     <= mag(rs2_val, b_signed);
      acc     <= {{XLEN{1'b0}}, mag(rs2_val, b_signed)};
      rem     <= '0;
      tag_out <= tag_in;
      illegal <= !is_m;
      if (fast) result <= fast_res;
    end else if (state == S_CALC) begin
      if (f3[2]) begin
        opa <= opa_nxt;
        rem <= rem_nxt;
      end else begin
        acc <= acc_nxt;
      end
      if (cnt == '0) result <= calc_res;
    end
  end

endmodule

// File: doc/rv32m_muldiv_unit.md
Name: rv32m_muldiv_unit

Overview:
- Iterative RV32M execution unit: decodes OP-class instructions with funct7=0000001 and computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Parametrised in data width and tag width, with valid/ready handshakes on input and output.
- Sits beside the single-cycle ALU in EX; the pipeline stalls on in_ready/out_valid.

Parameters:
XLEN, 32, operand/result width; must be even and >= 8
TAG_WIDTH, 5, width of opaque tag (e.g. rd index) carried from request to response

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  unit can accept request
opcode  in  7  instruction opcode
funct3  in  3  instruction funct3
funct7  in  7  instruction funct7
rs1_val  in  XLEN  operand A (multiplicand/dividend)
rs2_val  in  XLEN  operand B (multiplier/divisor)
tag_in  in  TAG_WIDTH  request tag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  XLEN  result value
tag_out  out  TAG_WIDTH  tag of returned result
illegal  out  1  request was not a valid M-extension encoding

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, result=0, tag_out=0, illegal=0, counter=0, all datapath regs 0. Reset mid-CALC or mid-DONE aborts the operation with no response.
- FSM states IDLE, CALC, DONE. in_ready=1 only in IDLE, so no new request is accepted in the cycle a result handshakes.
- IDLE: on in_valid&&in_ready, latch funct3, tag_in, and operand magnitudes. Signed operands are converted to magnitude and their sign is recorded:
  - MULH: both operands signed.
  - MULHSU: rs1 signed only.
  - DIV/REM: both operands signed.
- Accept with opcode!=OP or funct7!=0000001: go to DONE with result=0, illegal=1.
- Fast paths, going straight to DONE with out_valid visible 1 cycle after the accepting edge:
  - Divide by zero (rs2_val==0): DIV/DIVU give all ones; REM/REMU give rs1_val.
  - Signed overflow (DIV/REM with rs1=-2^(XLEN-1), rs2=-1): DIV gives rs1_val; REM gives 0.
- Otherwise go to CALC with counter=XLEN-1.
- CALC: one iteration per cycle.
  - Multiply: shift-add over a 2*XLEN accumulator, one multiplier bit per cycle.
  - Divide: restoring algorithm, one quotient bit per cycle, XLEN-bit partial remainder.
  - On the edge where counter==0, apply sign fix and go to DONE.
  - Latency from the accepting edge to out_valid is XLEN+1 cycles (33 for XLEN=32).
- Result selection (sign fix is two's-complement negation):
  - MUL: low XLEN bits of the product.
  - MULH/MULHSU/MULHU: high XLEN bits of the product.
  - Product is negated when the operand signs differ.
  - Quotient is negated when signs differ; remainder takes the sign of the dividend.
- DONE: out_valid=1; result, tag_out and illegal are stable while out_ready=0. On out_valid&&out_ready, go to IDLE and drop out_valid on the next edge. illegal returns to 0 on the next accepted request.
- in_valid during CALC/DONE is ignored; the requester holds it until in_ready.
- In IDLE with no accept, opcode/funct fields are don't-care; no $display or X-propagation on illegal input.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3), tag=5, out_ready=1 -> result=0xFFFFFFEB, tag_out=5, out_valid exactly 33 cycles after accept, in_ready low for those 33 cycles.
- Product high-half selects:
  - MULH 0x80000000*0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF(-1)*2 -> 0xFFFFFFFF.
- Signed divide/remainder:
  - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Fast paths, each with out_valid 1 cycle after accept:
  - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- Backpressure, illegal encoding, and reset:
  - Hold out_ready=0 for 10 cycles after out_valid -> result/tag stable, in_ready=0, second in_valid not accepted.
  - funct7=0000000 request -> illegal=1, result=0.
  - rst_n low during CALC cycle 12 -> out_valid=0, in_ready=1 immediately, next MUL 3*4 -> 12.
